// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline stages.
//   XLEN        : architectural register / data width
//   REG_AW      : register-file index width
//   result_src_e: writeback mux select (0 = ALU result, 1 = memory data)
package pipeline_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic {
    RES_ALU = 1'b0,
    RES_MEM = 1'b1
  } result_src_e;

endpackage : pipeline_pkg

// File: rtl/data_memory.sv
// Word-addressed data memory: DEPTH x XLEN array.
// Reads are asynchronous and writes are synchronous. There is no reset, so
// contents are undefined until they are written.
//   clk   : rising-edge clock
//   we    : write enable, a full word is written at the edge
//   addr  : word index
//   wdata : write data
//   rdata : combinational read data at addr (the pre-write value on a write edge)
module data_memory
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // The array is read before the edge updates it, which gives read-old
  // behaviour for a load and a store to the same word in the same cycle.
  assign rdata = mem[addr];

endmodule : data_memory

// File: rtl/memory_stage.sv
// Memory-access stage of the 5-stage RV32I pipeline.
// It performs the data-memory load or store for the M-stage instruction and
// registers the MEM/WB bundle consumed by writeback.
//   clk, rst         : clock, synchronous active-low reset
//   ValidM           : M slot holds a real instruction
//   StallM, FlushM   : hold W registers / squash M instruction (flush wins)
//   RegWriteM, MemWriteM, ResultSrcM, RdM : control bundle from execute
//   ALU_ResultM      : effective address / ALU result
//   WriteDataM       : store data
//   PCPlus4M         : link value
//   RegWriteW, ResultSrcW, ValidW, RdW        : registered control to W
//   ALU_ResultW, ReadDataW, PCPlus4W          : registered data to W
//   MisalignW        : W instruction was a misaligned load/store
module memory_stage
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidM,
  input  logic              StallM,
  input  logic              FlushM,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [REG_AW-1:0] RdM,
  input  logic [XLEN-1:0]   ALU_ResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  input  logic [XLEN-1:0]   PCPlus4M,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic              ValidW,
  output logic [REG_AW-1:0] RdW,
  output logic [XLEN-1:0]   ALU_ResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic [XLEN-1:0]   PCPlus4W,
  output logic              MisalignW
);

  // A word access is misaligned whenever either low address bit is set.
  function automatic logic addr_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // Upper address bits are dropped so accesses wrap modulo DEPTH words.
  function automatic logic [AW-1:0] word_index(input logic [XLEN-1:0] addr);
    return addr[AW+1:2];
  endfunction

  logic            mem_op_p0;
  logic            misalign_p0;
  logic            store_en_p0;
  logic [AW-1:0]   widx_p0;
  logic [XLEN-1:0] rdata_p0;

  logic              vld_p1;
  logic              regwrite_p1;
  logic              resultsrc_p1;
  logic              misalign_p1;
  logic [REG_AW-1:0] rd_p1;
  logic [XLEN-1:0]   alu_result_p1;
  logic [XLEN-1:0]   read_data_p1;
  logic [XLEN-1:0]   pcplus4_p1;

  // ---- M stage: access decode and data memory ----
  assign mem_op_p0   = ValidM & ~FlushM & (MemWriteM | (ResultSrcM == RES_MEM));
  assign misalign_p0 = mem_op_p0 & addr_misaligned(ALU_ResultM);
  assign widx_p0     = word_index(ALU_ResultM);

  // Reset is folded into the enable so a store in a reset cycle is dropped.
  assign store_en_p0 = rst & ValidM & ~FlushM & MemWriteM & ~misalign_p0 & ~StallM;

  data_memory #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dmem (
    .clk   (clk),
    .we    (store_en_p0),
    .addr  (widx_p0),
    .wdata (WriteDataM),
    .rdata (rdata_p0)
  );

  // ---- MEM/WB register bank ----
  // Priority: reset, then flush (bubble, overrides stall), then stall (hold).
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1        <= 1'b0;
      regwrite_p1   <= 1'b0;
      resultsrc_p1  <= 1'b0;
      misalign_p1   <= 1'b0;
      rd_p1         <= '0;
      alu_result_p1 <= '0;
      read_data_p1  <= '0;
      pcplus4_p1    <= '0;
    end else if (FlushM) begin
      vld_p1        <= 1'b0;
      regwrite_p1   <= 1'b0;
      resultsrc_p1  <= 1'b0;
      misalign_p1   <= 1'b0;
      rd_p1         <= '0;
      alu_result_p1 <= '0;
      read_data_p1  <= '0;
      pcplus4_p1    <= '0;
    end else if (!StallM) begin
      vld_p1        <= ValidM;
      regwrite_p1   <= RegWriteM & ValidM & ~misalign_p0;
      resultsrc_p1  <= ResultSrcM;
      misalign_p1   <= misalign_p0;
      rd_p1         <= RdM;
      alu_result_p1 <= ALU_ResultM;
      read_data_p1  <= ValidM ? rdata_p0 : '0;
      pcplus4_p1    <= PCPlus4M;
    end
  end

  // ---- W stage outputs ----
  assign ValidW      = vld_p1;
  assign RegWriteW   = regwrite_p1;
  assign ResultSrcW  = resultsrc_p1;
  assign MisalignW   = misalign_p1;
  assign RdW         = rd_p1;
  assign ALU_ResultW = alu_result_p1;
  assign ReadDataW   = read_data_p1;
  assign PCPlus4W    = pcplus4_p1;

endmodule : memory_stage

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: reset, store/load, address wrap,
// misalignment, stall/flush, read-old and reset-during-store.
module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic        ValidM, StallM, FlushM;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
  logic        RegWriteW, ResultSrcW, ValidW;
  logic [4:0]  RdW;
  logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;
  logic        MisalignW;

  int tests = 0;
  int fails = 0;

  memory_stage #(.DEPTH(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .ValidM      (ValidM),
    .StallM      (StallM),
    .FlushM      (FlushM),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RdM         (RdM),
    .ALU_ResultM (ALU_ResultM),
    .WriteDataM  (WriteDataM),
    .PCPlus4M    (PCPlus4M),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .ValidW      (ValidW),
    .RdW         (RdW),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW),
    .PCPlus4W    (PCPlus4W),
    .MisalignW   (MisalignW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one M-stage instruction (no stall, no flush).
  task automatic drive(input logic v, input logic rw, input logic mw, input logic rs,
                       input logic [4:0] rd, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] pc);
    ValidM = v; RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
    RdM = rd; ALU_ResultM = addr; WriteDataM = wd; PCPlus4M = pc;
    StallM = 1'b0; FlushM = 1'b0;
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".out"}, {RegWriteW, ResultSrcW, ValidW, MisalignW, RdW}, 32'd0);
    check({tag, ".alu"}, ALU_ResultW, 32'd0);
    check({tag, ".rdata"}, ReadDataW, 32'd0);
    check({tag, ".pc"}, PCPlus4W, 32'd0);
  endtask

  initial begin
    // Reset with nonzero inputs, including a store that must be dropped.
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0044, 32'h1357_9BDF, 32'h0000_0200);
    step();
    check_all_zero("reset1");
    step();
    check_all_zero("reset2");

    // Store then load.
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h10, 32'hDEAD_BEEF, 32'h104);
    step();
    check("st.valid", {31'd0, ValidW}, 32'd1);
    check("st.regw", {31'd0, RegWriteW}, 32'd0);
    check("st.alu", ALU_ResultW, 32'h10);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h10, 32'h0, 32'h108);
    step();
    check("ld.rdata", ReadDataW, 32'hDEAD_BEEF);
    check("ld.rd", {27'd0, RdW}, 32'd5);
    check("ld.regw", {31'd0, RegWriteW}, 32'd1);
    check("ld.rsrc", {31'd0, ResultSrcW}, 32'd1);
    check("ld.pc", PCPlus4W, 32'h108);

    // Address wrap: 4*DEPTH+8 aliases byte address 8.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_1008, 32'h0000_1234, 32'h10C);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h8, 32'h0, 32'h110);
    step();
    check("wrap.rdata", ReadDataW, 32'h0000_1234);

    // Misaligned store is flagged and suppressed.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h20, 32'hCAFE_F00D, 32'h114);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h21, 32'h0000_FFFF, 32'h118);
    step();
    check("mis.flag", {31'd0, MisalignW}, 32'd1);
    check("mis.regw", {31'd0, RegWriteW}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h20, 32'h0, 32'h11C);
    step();
    check("mis.prior", ReadDataW, 32'hCAFE_F00D);
    check("mis.clear", {31'd0, MisalignW}, 32'd0);
    check("mis.ldregw", {31'd0, RegWriteW}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h22, 32'h0, 32'h120);
    step();
    check("misld.flag", {31'd0, MisalignW}, 32'd1);
    check("misld.regw", {31'd0, RegWriteW}, 32'd0);

    // Stall: W holds, store does not commit; then flush+stall squashes it.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h30, 32'h1111_0000, 32'h124);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h34, 32'h2222_0000, 32'h128);
    ALU_ResultM = 32'h30;
    StallM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.pc", PCPlus4W, 32'h124);
      check("stall.alu", ALU_ResultW, 32'h30);
      check("stall.regw", {31'd0, RegWriteW}, 32'd0);
    end
    FlushM = 1'b1;
    step();
    check("flst.valid", {31'd0, ValidW}, 32'd0);
    check("flst.regw", {31'd0, RegWriteW}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 32'h30, 32'h0, 32'h12C);
    step();
    check("stall.mem", ReadDataW, 32'h1111_0000);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h30, 32'h2222_0000, 32'h130);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 32'h30, 32'h0, 32'h134);
    step();
    check("stall.after", ReadDataW, 32'h2222_0000);

    // Read-old on simultaneous load and store to the same word.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h40, 32'hA5A5_A5A5, 32'h138);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'h40, 32'h5A5A_5A5A, 32'h13C);
    step();
    check("rold.old", ReadDataW, 32'hA5A5_A5A5);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h40, 32'h0, 32'h140);
    step();
    check("rold.new", ReadDataW, 32'h5A5A_5A5A);

    // Invalid slot: fields load but ReadDataW, RegWriteW and ValidW are 0.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h40, 32'h0, 32'h144);
    step();
    check("inv.valid", {31'd0, ValidW}, 32'd0);
    check("inv.regw", {31'd0, RegWriteW}, 32'd0);
    check("inv.rdata", ReadDataW, 32'd0);
    check("inv.alu", ALU_ResultW, 32'h40);

    // Flush alone: bubble and no store commit.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h40, 32'h0000_0000, 32'h148);
    FlushM = 1'b1;
    step();
    check("flush.alu", ALU_ResultW, 32'd0);
    check("flush.valid", {31'd0, ValidW}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'h40, 32'h0, 32'h14C);
    step();
    check("flush.mem", ReadDataW, 32'h5A5A_5A5A);

    // Reset during a store drops the store.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h40, 32'h0000_0099, 32'h150);
    rst = 1'b0;
    step();
    check_all_zero("rstst");
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'h40, 32'h0, 32'h154);
    step();
    check("rstst.mem", ReadDataW, 32'h5A5A_5A5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_memory_stage
